// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: upstream instruction/operand side, flush,
// and the registered decoded-instruction side towards the ALU.
// slave = stage view, master = environment (fetch/regfile + ALU) view.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  // upstream side
  logic            in_valid_in;
  logic            in_ready_out;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic            flush_in;
  // downstream side
  logic            out_valid_out;
  logic            out_ready_in;
  logic [3:0]      alu_opcode_out;
  logic [XLEN-1:0] op_1_out;
  logic [XLEN-1:0] op_2_out;
  logic [4:0]      rd_addr_out;
  logic            rd_wr_en_out;
  logic            illegal_out;

  modport slave (
    input  in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in,
    input  flush_in, out_ready_in,
    output in_ready_out, out_valid_out, alu_opcode_out, op_1_out, op_2_out,
    output rd_addr_out, rd_wr_en_out, illegal_out
  );

  modport master (
    output in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in,
    output flush_in, out_ready_in,
    input  in_ready_out, out_valid_out, alu_opcode_out, op_1_out, op_2_out,
    input  rd_addr_out, rd_wr_en_out, illegal_out
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Purpose: RV32I decode/issue stage feeding the ALU (OP, OP-IMM, LUI, AUIPC).
// Latency: 1 cycle from acceptance to out_valid_out; one instruction per cycle.
// Backpressure: in_ready_out = !out_valid_out | out_ready_in; flush drops held and incoming.
// Ports: clk_in/rst_in (async active-high) plus bus (alu_issue_stage_if.slave):
//   in_valid/in_ready handshake with instr, pc, rs1/rs2 data; flush_in;
//   out_valid/out_ready handshake with opcode, op_1, op_2, rd, wr_en, illegal.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  alu_issue_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_shift_f3;

  assign opc         = bus.instr_in[6:0];
  assign funct3      = bus.instr_in[14:12];
  assign funct7      = bus.instr_in[31:25];
  assign rd          = bus.instr_in[11:7];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Source register addresses are resolved by the register file upstream.
  logic unused_rs1_addr;
  assign unused_rs1_addr = ^bus.instr_in[19:15];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_imm;
  logic [XLEN-1:0] shamt_reg;

  assign imm_i     = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
  assign imm_u     = {bus.instr_in[31:12], 12'b0};
  assign shamt_imm = {{(XLEN-5){1'b0}}, bus.instr_in[24:20]};
  // ALU shifts by the whole operand, so only the low 5 bits of rs2 may pass.
  assign shamt_reg = {{(XLEN-5){1'b0}}, bus.rs2_data_in[4:0]};

  // ---------------- decode ----------------
  logic            dec_illegal;
  logic [3:0]      dec_opcode;
  logic [XLEN-1:0] dec_op_1;
  logic [XLEN-1:0] dec_op_2;

  // Opcode compare covers instr[1:0]==11, since every legal major opcode ends in 11.
  always_comb begin
    dec_illegal = 1'b1;
    dec_opcode  = 4'b0000;
    dec_op_1    = '0;
    dec_op_2    = '0;
    case (opc)
      OPC_OP: begin
        if ((funct7 == F7_ZERO) ||
            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec_illegal = 1'b0;
          dec_opcode  = {bus.instr_in[30], funct3};
          dec_op_1    = bus.rs1_data_in;
          dec_op_2    = is_shift_f3 ? shamt_reg : bus.rs2_data_in;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          if (funct7 == F7_ZERO) begin
            dec_illegal = 1'b0;
            dec_opcode  = 4'b0001;
            dec_op_1    = bus.rs1_data_in;
            dec_op_2    = shamt_imm;
          end
        end else if (funct3 == 3'b101) begin
          if ((funct7 == F7_ZERO) || (funct7 == F7_ALT)) begin
            dec_illegal = 1'b0;
            dec_opcode  = {bus.instr_in[30], 3'b101};
            dec_op_1    = bus.rs1_data_in;
            dec_op_2    = shamt_imm;
          end
        end else begin
          // Immediate forms never use the alternate encoding (no SUBI).
          dec_illegal = 1'b0;
          dec_opcode  = {1'b0, funct3};
          dec_op_1    = bus.rs1_data_in;
          dec_op_2    = imm_i;
        end
      end
      OPC_LUI: begin
        dec_illegal = 1'b0;
        dec_op_2    = imm_u;
      end
      OPC_AUIPC: begin
        dec_illegal = 1'b0;
        dec_op_1    = bus.pc_in;
        dec_op_2    = imm_u;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ---------------- pipeline register ----------------
  logic            out_valid_q,  out_valid_d;
  logic [3:0]      alu_opcode_q, alu_opcode_d;
  logic [XLEN-1:0] op_1_q,       op_1_d;
  logic [XLEN-1:0] op_2_q,       op_2_d;
  logic [4:0]      rd_addr_q,    rd_addr_d;
  logic            rd_wr_en_q,   rd_wr_en_d;
  logic            illegal_q,    illegal_d;

  logic in_ready;
  logic capture;

  assign in_ready = !out_valid_q || bus.out_ready_in;
  assign capture  = bus.in_valid_in && in_ready && !bus.flush_in;

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_opcode_d = alu_opcode_q;
    op_1_d       = op_1_q;
    op_2_d       = op_2_q;
    rd_addr_d    = rd_addr_q;
    rd_wr_en_d   = rd_wr_en_q;
    illegal_d    = illegal_q;
    if (bus.flush_in) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      // Covers both an empty stage and drain-plus-refill in the same cycle.
      out_valid_d  = 1'b1;
      alu_opcode_d = dec_opcode;
      op_1_d       = dec_op_1;
      op_2_d       = dec_op_2;
      rd_addr_d    = rd;
      rd_wr_en_d   = !dec_illegal && (rd != 5'd0);
      illegal_d    = dec_illegal;
    end else if (bus.out_ready_in) begin
      // Drain: data registers keep their last contents.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_q  <= 1'b0;
      alu_opcode_q <= '0;
      op_1_q       <= '0;
      op_2_q       <= '0;
      rd_addr_q    <= '0;
      rd_wr_en_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_opcode_q <= alu_opcode_d;
      op_1_q       <= op_1_d;
      op_2_q       <= op_2_d;
      rd_addr_q    <= rd_addr_d;
      rd_wr_en_q   <= rd_wr_en_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.in_ready_out   = in_ready;
  assign bus.out_valid_out  = out_valid_q;
  assign bus.alu_opcode_out = alu_opcode_q;
  assign bus.op_1_out       = op_1_q;
  assign bus.op_2_out       = op_2_q;
  assign bus.rd_addr_out    = rd_addr_q;
  assign bus.rd_wr_en_out   = rd_wr_en_q;
  assign bus.illegal_out    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: hand-computed expected decodes are queued on acceptance
// and compared every cycle the stage holds them, popped when consumed or flushed.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  opc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic exp_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid_out), 32'(exp_valid));
    if (exp_valid && sb.size() != 0) begin
      chk("opcode",  32'(bus.alu_opcode_out), 32'(sb[0].opc));
      chk("op_1",    bus.op_1_out,            sb[0].op1);
      chk("op_2",    bus.op_2_out,            sb[0].op2);
      chk("rd_addr", 32'(bus.rd_addr_out),    32'(sb[0].rd));
      chk("rd_wr",   32'(bus.rd_wr_en_out),   32'(sb[0].wr));
      chk("illegal", 32'(bus.illegal_out),    32'(sb[0].ill));
    end
  endtask

  // One cycle: check what the stage holds, present new inputs, update the model.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic fl, input logic rdy, input exp_t e);
    logic exp_rdy;
    logic acc;
    @(negedge clk_in);
    check_outputs();
    bus.in_valid_in  = v;
    bus.instr_in     = ins;
    bus.pc_in        = pc;
    bus.rs1_data_in  = r1;
    bus.rs2_data_in  = r2;
    bus.flush_in     = fl;
    bus.out_ready_in = rdy;
    #1;
    exp_rdy = !exp_valid || rdy;
    chk("in_ready", 32'(bus.in_ready_out), 32'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (fl) sb.delete();
    else if (exp_valid && rdy) void'(sb.pop_front());
    if (acc) sb.push_back(e);
    exp_valid = acc || (exp_valid && !rdy && !fl);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, '0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"},   32'(bus.out_valid_out),  32'h0);
    chk({tag, "_opcode"},  32'(bus.alu_opcode_out), 32'h0);
    chk({tag, "_op_1"},    bus.op_1_out,            32'h0);
    chk({tag, "_op_2"},    bus.op_2_out,            32'h0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr_out),    32'h0);
    chk({tag, "_rd_wr"},   32'(bus.rd_wr_en_out),   32'h0);
    chk({tag, "_illegal"}, 32'(bus.illegal_out),    32'h0);
  endtask

  // expected records {opcode, op_1, op_2, rd, wr_en, illegal}
  localparam exp_t E_ADD   = '{4'b0000, 32'h5,        32'hFFFF_FFFE, 5'd3, 1'b1, 1'b0};
  localparam exp_t E_SRAI  = '{4'b1101, 32'h8000_0000, 32'h4,       5'd5, 1'b1, 1'b0};
  localparam exp_t E_SRA   = '{4'b1101, 32'hF000_0000, 32'h4,       5'd7, 1'b1, 1'b0};
  localparam exp_t E_ADDI  = '{4'b0000, 32'h0,        32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0};
  localparam exp_t E_AUIPC = '{4'b0000, 32'h100,      32'h1234_5000, 5'd2, 1'b1, 1'b0};
  localparam exp_t E_LUI0  = '{4'b0000, 32'h0,        32'h0000_1000, 5'd0, 1'b0, 1'b0};
  localparam exp_t E_SUB   = '{4'b1000, 32'd10,       32'd3,         5'd4, 1'b1, 1'b0};
  localparam exp_t E_SLL   = '{4'b0001, 32'h1,        32'h1,         5'd5, 1'b1, 1'b0};
  localparam exp_t E_XORI  = '{4'b0100, 32'h0F0F_0F0F, 32'hFFFF_F800, 5'd8, 1'b1, 1'b0};
  localparam exp_t E_ILL7F = '{4'b0000, 32'h0,        32'h0,         5'd0, 1'b0, 1'b1};
  localparam exp_t E_ILLOP = '{4'b0000, 32'h0,        32'h0,         5'd3, 1'b0, 1'b1};
  localparam exp_t E_ILLSL = '{4'b0000, 32'h0,        32'h0,         5'd1, 1'b0, 1'b1};
  localparam exp_t E_ILLLO = '{4'b0000, 32'h0,        32'h0,         5'd3, 1'b0, 1'b1};

  initial begin
    bus.in_valid_in  = 1'b0;
    bus.instr_in     = 32'h0;
    bus.pc_in        = 32'h0;
    bus.rs1_data_in  = 32'h0;
    bus.rs2_data_in  = 32'h0;
    bus.flush_in     = 1'b0;
    bus.out_ready_in = 1'b1;

    // reset state
    #2;
    check_cleared("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready_out), 32'h1);

    // back-to-back decode stream, downstream always ready
    drive(1'b1, 32'h002081B3, 32'h0,   32'h5,         32'hFFFF_FFFE, 1'b0, 1'b1, E_ADD);
    drive(1'b1, 32'h40435293, 32'h0,   32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, E_SRAI);
    drive(1'b1, 32'h409453B3, 32'h0,   32'hF000_0000, 32'h0000_0124, 1'b0, 1'b1, E_SRA);
    drive(1'b1, 32'hFFF00093, 32'h0,   32'h0,         32'h0000_0055, 1'b0, 1'b1, E_ADDI);
    drive(1'b1, 32'h12345117, 32'h100, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, E_AUIPC);
    drive(1'b1, 32'h00001037, 32'h200, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, E_LUI0);
    drive(1'b1, 32'h40208233, 32'h0,   32'd10,        32'd3,         1'b0, 1'b1, E_SUB);
    drive(1'b1, 32'h002092B3, 32'h0,   32'h1,         32'hFFFF_FF21, 1'b0, 1'b1, E_SLL);
    drive(1'b1, 32'h8004C413, 32'h0,   32'h0F0F_0F0F, 32'h0,         1'b0, 1'b1, E_XORI);
    drive(1'b1, 32'h0000007F, 32'h40,  32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, E_ILL7F);
    drive(1'b1, 32'h4020F1B3, 32'h0,   32'h7,         32'h9,         1'b0, 1'b1, E_ILLOP);
    drive(1'b1, 32'h40001093, 32'h0,   32'h7,         32'h9,         1'b0, 1'b1, E_ILLSL);
    drive(1'b1, 32'h002081B0, 32'h0,   32'h7,         32'h9,         1'b0, 1'b1, E_ILLLO);
    idle(1'b1);
    idle(1'b1);

    // backpressure: hold ADD while SUB waits, then release with no bubble
    drive(1'b1, 32'h002081B3, 32'h0, 32'h5,  32'hFFFF_FFFE, 1'b0, 1'b1, E_ADD);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h40208233, 32'h0, 32'd10, 32'd3, 1'b0, 1'b0, E_SUB);
    drive(1'b1, 32'h40208233, 32'h0, 32'd10, 32'd3, 1'b0, 1'b1, E_SUB);
    idle(1'b0);
    idle(1'b1);

    // flush while holding a stalled instruction with a new one presented
    drive(1'b1, 32'h40435293, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, E_SRAI);
    drive(1'b1, 32'hFFF00093, 32'h0, 32'h0,         32'h0, 1'b1, 1'b0, E_ADDI);
    idle(1'b1);
    // flush with the stage empty also drops the incoming instruction
    drive(1'b1, 32'h12345117, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1, E_AUIPC);
    idle(1'b1);

    // asynchronous reset in the middle of a stall
    drive(1'b1, 32'h002092B3, 32'h0, 32'h1, 32'hFFFF_FF21, 1'b0, 1'b1, E_SLL);
    drive(1'b1, 32'h40208233, 32'h0, 32'd10, 32'd3, 1'b0, 1'b0, E_SUB);
    @(negedge clk_in);
    check_outputs();
    bus.in_valid_in  = 1'b0;
    bus.out_ready_in = 1'b0;
    #1;
    rst_in = 1'b1;
    #1;
    check_cleared("midreset");
    #1;
    rst_in = 1'b0;
    sb.delete();
    exp_valid = 1'b0;
    #1;
    chk("midreset_in_ready", 32'(bus.in_ready_out), 32'h1);

    // upstream re-issues after the reset
    drive(1'b1, 32'h40208233, 32'h0, 32'd10, 32'd3, 1'b0, 1'b1, E_SUB);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage directly upstream of the ALU in the RV32I core.
- Accepts a fetched instruction, its PC and the register-file read data. Decodes OP, OP-IMM, LUI and AUIPC into the ALU's 4-bit opcode and two 32-bit operands.
- Holds the result in a single pipeline register with valid/ready handshake and flush, and forwards the destination-register info to writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- in_valid_in  input  1  upstream presents an instruction.
- in_ready_out  output  1  stage can accept this cycle.
- instr_in  input  32  raw RV32I instruction word.
- pc_in  input  32  PC of instr_in.
- rs1_data_in  input  32  register-file value for instr_in[19:15].
- rs2_data_in  input  32  register-file value for instr_in[24:20].
- flush_in  input  1  discard held and incoming instruction.
- out_valid_out  output  1  registered outputs hold a decoded instruction.
- out_ready_in  input  1  downstream consumes this cycle.
- alu_opcode_out  output  4  ALU opcode, registered.
- op_1_out  output  32  ALU operand 1, registered.
- op_2_out  output  32  ALU operand 2, registered.
- rd_addr_out  output  5  destination register, registered.
- rd_wr_en_out  output  1  writeback enable; 0 when rd=0 or illegal.
- illegal_out  output  1  instruction not decodable by this stage.

Behaviour:
- Reset (async, rst_in=1): out_valid_out=0, all registered outputs 0. in_ready_out=1 once reset deasserts.
- in_ready_out = !out_valid_out | out_ready_in (combinational; no flush term).
- Capture: in_valid_in & in_ready_out & !flush_in at the edge → load the decoded fields, out_valid_out=1. Latency is 1 cycle from acceptance to out_valid_out.
- Drain: out_valid_out & out_ready_in with no capture → out_valid_out=0 next cycle. Data registers hold their values.
- Stall: out_valid_out & !out_ready_in → all outputs frozen; in_ready_out=0.
- Simultaneous drain and capture → new instruction replaces the old one, out_valid_out stays 1. There is no bubble: full throughput is one instruction per cycle.
- flush_in=1 → next cycle out_valid_out=0, and any same-cycle input is dropped. Flush overrides capture and stall.
- ALU opcode encoding: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- OP (0110011):
  - funct7 must be 0000000, or 0100000 only with funct3 000 or 101.
  - opcode = {instr[30], funct3}; op_1=rs1_data_in.
  - op_2=rs2_data_in, except shifts (funct3 001/101): op_2={27'b0, rs2_data_in[4:0]}, because the ALU shifts by the full operand.
- OP-IMM (0010011):
  - op_1=rs1_data_in; op_2=sign-extended instr[31:20]; opcode={1'b0, funct3}.
  - SLLI: funct7 must be 0.
  - SRLI/SRAI: funct7 must be 0000000 or 0100000. opcode={instr[30], 101}; op_2={27'b0, instr[24:20]}.
- LUI (0110111): opcode ADD, op_1=0, op_2={instr[31:12], 12'b0}.
- AUIPC (0010111): opcode ADD, op_1=pc_in, op_2={instr[31:12], 12'b0}.
- rd_addr_out=instr[11:7]; rd_wr_en_out=1 only for a legal instruction with rd≠0.
- Anything else (other major opcodes, bad funct7, instr[1:0]≠11):
  - illegal_out=1, opcode 0000, operands 0, rd_wr_en_out=0.
  - The instruction still handshakes normally (out_valid_out=1) so the trap logic sees it.
- Reset mid-stall: outputs clear immediately (async). The held instruction is lost and upstream re-issues it.

Test Plan:
- Reset and basic ADD:
  - Reset, then ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=0xFFFFFFFE, out_ready=1.
  - Next cycle: out_valid=1, opcode 0000, op_1=5, op_2=0xFFFFFFFE, rd=3, wr_en=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000:
  - Opcode 1101, op_2=4, op_1=0x80000000.
  - SRA via OP with rs2=0x00000124 → op_2=4.
- Immediates:
  - ADDI x1,x0,-1 (0xFFF00093): opcode 0000 (not SUB), op_2=0xFFFFFFFF.
  - AUIPC x2,0x12345 at pc=0x100: op_1=0x100, op_2=0x12345000.
  - LUI x0,1: wr_en=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with a second instruction presented.
  - Outputs stable and in_ready=0 throughout.
  - Raise out_ready: the second instruction loads the next cycle with no bubble.
- Flush:
  - Assert flush_in while out_valid=1 and a new instr is valid.
  - Next cycle out_valid=0; the new instr is not captured.
- Illegal decode:
  - Instr 0x0000007F → out_valid=1, illegal=1, opcode 0, op_1=op_2=0, wr_en=0.
  - OP with funct7=0100000, funct3=111 → illegal=1.
